acc_ctrl_event_tx: RTL and testbench

Multi-channel successor to the single-channel ACC control transmitter. It watches CH_NUM filter/ACC control levels and turns every rising or falling edge into a class code word. Bursts of changes are coalesced per channel and arbitrated round-robin into a small FWFT FIFO. It optionally re-sends the current state of all channels on a periodic refresh. The output valid/ready/data port connects directly to `serial_tx` (tx_valid_i / tx_ready_o / tx_data_i).

---
 rtl/acc_ctrl_event_tx.sv | 153 +++++++++++++++
 tb/tb_acc_ctrl_event_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_ctrl_event_tx.sv
// acc_ctrl_event_tx: turns edges on CH_NUM control levels into class code words,
// coalesced per channel and arbitrated round-robin into a FWFT FIFO.
module acc_ctrl_event_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_NUM = 4,
  parameter int FIFO_DEPTH = 8,
  parameter logic [DATA_WIDTH-9:0] CODE_PREFIX = 'h5A,
  parameter int CH_BASE = 5,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [CH_NUM-1:0]            filter_acc_ctrl_i,
  input  logic                         cnt_clr_i,
  output logic                         tx_valid_o,
  input  logic                         tx_ready_i,
  output logic [DATA_WIDTH-1:0]        tx_data_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
  output logic [15:0]                  coalesce_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [CH_NUM-1:0]     lvl_q;
  logic [CH_NUM-1:0]     chg;
  logic [CH_NUM-1:0]     pend;
  logic [CH_NUM-1:0]     pend_lvl;
  logic [CW-1:0]         last_grant;
  logic                  grant_valid;
  logic [CW-1:0]         grant_ch;
  logic [CW-1:0]         cand;
  int                    rr_idx;
  logic                  refresh_hit;
  logic [3:0]            ch_field;
  logic [DATA_WIDTH-1:0] code_word;
  logic [16:0]           cnt_sum;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           level;
  logic                  fifo_full;
  logic                  pop;

  assign chg = lvl_q ^ filter_acc_ctrl_i;

  generate
    if (REFRESH_CYCLES > 0) begin : g_refresh
      logic [RW-1:0] refresh_cnt;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          refresh_cnt <= '0;
        end else if (refresh_cnt == RW'(REFRESH_CYCLES - 1)) begin
          refresh_cnt <= '0;
        end else begin
          refresh_cnt <= refresh_cnt + RW'(1);
        end
      end
      assign refresh_hit = (refresh_cnt == RW'(REFRESH_CYCLES - 1));
    end else begin : g_no_refresh
      assign refresh_hit = 1'b0;
    end
  endgenerate

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    rr_idx      = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      rr_idx = int'(last_grant) + 1 + i;
      if (rr_idx >= CH_NUM) rr_idx = rr_idx - CH_NUM;
      cand = CW'(rr_idx);
      if (!grant_valid && pend[cand] && !fifo_full) begin
        grant_valid = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  assign ch_field  = 4'(int'(grant_ch) + CH_BASE);
  assign code_word = {CODE_PREFIX, ch_field, 3'b000, pend_lvl[grant_ch]};

  // Each channel whose new edge lands on an un-granted pending entry merges one event.
  always_comb begin
    cnt_sum = {1'b0, coalesce_cnt_o};
    for (int c = 0; c < CH_NUM; c++) begin
      if (chg[c] && pend[c] && !(grant_valid && grant_ch == CW'(c))) begin
        cnt_sum = cnt_sum + 17'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lvl_q          <= '0;
      pend           <= '0;
      pend_lvl       <= '0;
      last_grant     <= CW'(CH_NUM - 1);
      coalesce_cnt_o <= '0;
    end else begin
      lvl_q <= filter_acc_ctrl_i;
      for (int c = 0; c < CH_NUM; c++) begin
        if (refresh_hit || chg[c]) begin
          pend[c]     <= 1'b1;
          pend_lvl[c] <= filter_acc_ctrl_i[c];
        end else if (grant_valid && grant_ch == CW'(c)) begin
          pend[c] <= 1'b0;
        end
      end
      if (grant_valid) last_grant <= grant_ch;
      if (cnt_clr_i) begin
        coalesce_cnt_o <= '0;
      end else if (cnt_sum[16]) begin
        coalesce_cnt_o <= 16'hFFFF;
      end else begin
        coalesce_cnt_o <= cnt_sum[15:0];
      end
    end
  end

  // Handshake: a word transfers on any clk_i edge where tx_valid_o && tx_ready_i;
  // while tx_valid_o is high and tx_ready_i low, tx_data_o is held unchanged.
  assign fifo_full  = (level == (AW+1)'(FIFO_DEPTH));
  assign tx_valid_o = (level != '0);
  assign pop        = tx_valid_o && tx_ready_i;

  always_ff @(posedge clk_i) begin
    if (grant_valid) mem[wr_ptr] <= code_word;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (grant_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({grant_valid, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign tx_data_o    = tx_valid_o ? mem[rd_ptr] : '0;
  assign fifo_level_o = level;

endmodule

// File: tb/tb_acc_ctrl_event_tx.sv
// Testbench for acc_ctrl_event_tx: vector table, directed corner sequences,
// randomized traffic against a queue-based reference model, and a refresh instance.
module tb_acc_ctrl_event_tx;
  localparam int CH    = 4;
  localparam int DEPTH = 8;
  localparam int W     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [CH-1:0] ctrl;
  logic          cnt_clr;
  logic          ready;
  logic          tx_valid;
  logic [W-1:0]  tx_data;
  logic [3:0]    fifo_level;
  logic [15:0]   coal_cnt;

  logic          r_rst_n;
  logic [CH-1:0] r_ctrl;
  logic          r_clr;
  logic          r_ready;
  logic          r_valid;
  logic [W-1:0]  r_data;
  logic [3:0]    r_level;
  logic [15:0]   r_coal;

  acc_ctrl_event_tx #(.REFRESH_CYCLES(0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .filter_acc_ctrl_i(ctrl), .cnt_clr_i(cnt_clr),
    .tx_valid_o(tx_valid), .tx_ready_i(ready), .tx_data_o(tx_data),
    .fifo_level_o(fifo_level), .coalesce_cnt_o(coal_cnt)
  );

  acc_ctrl_event_tx #(.REFRESH_CYCLES(100)) dut_ref (
    .clk_i(clk), .rst_n_i(r_rst_n), .filter_acc_ctrl_i(r_ctrl), .cnt_clr_i(r_clr),
    .tx_valid_o(r_valid), .tx_ready_i(r_ready), .tx_data_o(r_data),
    .fifo_level_o(r_level), .coalesce_cnt_o(r_coal)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  bit m_lvl[CH];
  bit m_pend[CH];
  bit m_plvl[CH];
  int m_last;
  int m_cnt;

  function automatic logic [W-1:0] word_of(input int c, input bit lvl);
    return 16'h5A00 + W'(((c + 5) % 16) * 16) + W'(lvl);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_lvl[c] = 1'b0; m_pend[c] = 1'b0; m_plvl[c] = 1'b0;
    end
    m_last = CH - 1;
    m_cnt  = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step(input logic [CH-1:0] in, input bit rdy, input bit clr);
    bit full;
    bit chg;
    int g;
    full = (exp_q.size() >= DEPTH);
    if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
    g = -1;
    if (!full) begin
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (m_last + k) % CH;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    if (g >= 0) begin
      exp_q.push_back(word_of(g, m_plvl[g]));
      m_last = g;
    end
    for (int c = 0; c < CH; c++) begin
      chg = (m_lvl[c] != in[c]);
      if (chg && m_pend[c] && c != g && m_cnt < 65535) m_cnt++;
      if (c == g) m_pend[c] = 1'b0;
      if (chg) begin
        m_pend[c] = 1'b1;
        m_plvl[c] = in[c];
      end
      m_lvl[c] = in[c];
    end
    if (clr) m_cnt = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [CH-1:0] c);
    rst_n = 1'b0; ctrl = c; ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cycle(input logic [CH-1:0] c, input bit rdy, input bit clr);
    ctrl = c; ready = rdy; cnt_clr = clr;
    model_step(c, rdy, clr);
    @(posedge clk);
    #1;
    check("valid", tx_valid, exp_q.size() != 0);
    check("level", fifo_level, exp_q.size());
    if (exp_q.size() > 0) check("data", tx_data, exp_q[0]);
    check("coal_cnt", coal_cnt, m_cnt);
  endtask

  typedef struct {
    bit            do_rst;
    logic [CH-1:0] ctrl;
    bit            ready;
    bit            exp_valid;
    logic [W-1:0]  exp_data;
    int            exp_level;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [CH-1:0] c;
    logic [W-1:0]  last_ch1;
    logic [W-1:0]  words[$];
    int            cycs[$];
    int            mask;

    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 16'h0000, 0};
    vecs[1]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 16'h5A51, 1};
    vecs[2]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 16'h5A61, 1};
    vecs[3]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 16'h5A71, 1};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 16'h5A81, 1};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 16'h0000, 0};
    vecs[6]  = '{1'b1, 4'b0001, 1'b1, 1'b0, 16'h0000, 0};
    vecs[7]  = '{1'b0, 4'b0001, 1'b1, 1'b1, 16'h5A51, 1};
    vecs[8]  = '{1'b0, 4'b0001, 1'b1, 1'b0, 16'h0000, 0};
    vecs[9]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000, 0};
    vecs[10] = '{1'b0, 4'b0000, 1'b1, 1'b1, 16'h5A50, 1};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000, 0};

    r_rst_n = 1'b0; r_ctrl = 4'b0101; r_clr = 1'b0; r_ready = 1'b1;
    rst_n = 1'b0; ctrl = '0; cnt_clr = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", tx_valid, 0);
    check("reset_data", tx_data, 0);
    check("reset_level", fifo_level, 0);
    check("reset_coal", coal_cnt, 0);

    // Vector table: simultaneous edges, then single-channel rise/fall.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_rst) do_reset('0);
      ctrl = vecs[i].ctrl; ready = vecs[i].ready; cnt_clr = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), tx_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_level);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), tx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_coal", i), coal_cnt, 0);
    end

    // Backpressure and coalescing: ch1 toggles 19 times (ends high), ch2 once.
    do_reset('0);
    c = '0;
    for (int i = 0; i < 20; i++) begin
      if (i < 19) c[1] = ~c[1];
      if (i == 5) c[2] = ~c[2];
      cycle(c, 1'b0, 1'b0);
    end
    check("bp_coal_nonzero", coal_cnt != 0, 1);
    last_ch1 = '0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid && tx_data[7:4] == 4'h6) last_ch1 = tx_data;
      cycle(c, 1'b1, 1'b0);
    end
    check("bp_last_ch1", last_ch1, 16'h5A61);
    cycle(c, 1'b1, 1'b1);
    check("clr_coal", coal_cnt, 0);

    // Full FIFO: 12 round-robin events with ready low, then drain.
    do_reset('0);
    c = '0;
    for (int i = 0; i < 12; i++) begin
      c[i % CH] = ~c[i % CH];
      cycle(c, 1'b0, 1'b0);
    end
    repeat (4) cycle(c, 1'b0, 1'b0);
    check("full_level", fifo_level, DEPTH);
    repeat (20) cycle(c, 1'b1, 1'b0);

    // Asynchronous reset mid-burst discards all queued and pending events.
    do_reset('0);
    repeat (6) cycle(4'b1111, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", tx_valid, 0);
    check("midrst_level", fifo_level, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (8) cycle(4'b1111, 1'b1, 1'b0);

    // Randomized traffic against the model.
    do_reset(CH'($urandom_range(0, 15)));
    c = ctrl;
    for (int i = 0; i < 3000; i++) begin
      bit rdy;
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 5) == 0) c[k] = ~c[k];
      end
      rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle(c, rdy, $urandom_range(0, 99) == 0);
    end

    // Refresh instance: constant 0101, ready high.
    repeat (2) @(posedge clk);
    #1;
    r_rst_n = 1'b1;
    for (int i = 0; i < 330; i++) begin
      @(posedge clk);
      #1;
      if (r_valid) begin
        words.push_back(r_data);
        cycs.push_back(i);
      end
    end
    check("ref_words", words.size(), 14);
    check("ref_coal", r_coal, 0);
    if (words.size() >= 14) begin
      check("ref_init0", words[0], 16'h5A51);
      check("ref_init1", words[1], 16'h5A71);
      for (int b = 0; b < 3; b++) begin
        mask = 0;
        for (int k = 0; k < 4; k++) begin
          case (words[2 + 4*b + k])
            16'h5A51: mask = mask | 1;
            16'h5A60: mask = mask | 2;
            16'h5A71: mask = mask | 4;
            16'h5A80: mask = mask | 8;
            default:  mask = mask | 16;
          endcase
          if (k > 0) check($sformatf("ref_b%0d_consec", b), cycs[2 + 4*b + k] - cycs[2 + 4*b + k - 1], 1);
        end
        check($sformatf("ref_b%0d_set", b), mask, 15);
        if (b > 0) check($sformatf("ref_b%0d_period", b), cycs[2 + 4*b] - cycs[2 + 4*(b-1)], 100);
      end
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
